// File: rtl/ssd_sink_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : ssd_sink_pkg                                       |
// | Description : Opcodes, addressing-mode and parser-state types,   |
// |               and the opcode argument-count lookup used by the   |
// |               SSD1306 SPI sink.                                  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package ssd_sink_pkg;

   localparam logic [7:0] OP_SET_MODE  = 8'h20;
   localparam logic [7:0] OP_COL_ADDR  = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
   localparam logic [7:0] OP_CONTRAST  = 8'h81;
   localparam logic [7:0] OP_CHARGE    = 8'h8D;
   localparam logic [7:0] OP_MUX       = 8'hA8;
   localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
   localparam logic [7:0] OP_DISP_ON   = 8'hAF;
   localparam logic [7:0] OP_OFFSET    = 8'hD3;
   localparam logic [7:0] OP_CLKDIV    = 8'hD5;
   localparam logic [7:0] OP_PRECHG    = 8'hD9;
   localparam logic [7:0] OP_COMPINS   = 8'hDA;
   localparam logic [7:0] OP_VCOMH     = 8'hDB;

   // 0xB0..0xB7 share this upper five-bit pattern
   localparam logic [4:0] OP_PAGE_SEL_HI = 5'b10110;

   typedef enum logic [1:0] {
      HORIZ = 2'd0,
      VERT  = 2'd1,
      PAGE  = 2'd2
   } addr_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARG1 = 2'd1,
      ARG2 = 2'd2
   } parse_state_e;

   // Number of argument bytes that follow an opcode (0..2)
   function automatic logic [1:0] arg_count(input logic [7:0] op);
      logic [1:0] n;
      n = 2'd0;
      case (op)
         OP_SET_MODE, OP_CONTRAST, OP_MUX, OP_OFFSET, OP_CHARGE,
         OP_CLKDIV, OP_PRECHG, OP_COMPINS, OP_VCOMH: n = 2'd1;
         OP_COL_ADDR, OP_PAGE_ADDR:                  n = 2'd2;
         default:                                    n = 2'd0;
      endcase
      return n;
   endfunction

endpackage : ssd_sink_pkg
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : spi_byte_rx                                        |
// | Description : Synchronizes the SPI pins into clk, detects SCLK   |
// |               rising edges and assembles MSB-first bytes. Emits  |
// |               a one-cycle valid with the byte and its DC level.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module spi_byte_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       sdin,
   input  logic       cs_n,
   input  logic       dc,
   input  logic       res_n,
   output logic [7:0] rx_byte,
   output logic       rx_dc,
   output logic       rx_valid,
   output logic       sync_res_n
);

   // Pin bundle order: {sclk, sdin, cs_n, dc, res_n}
   localparam logic [4:0] SYNC_RST_VAL = 5'b00100;

   logic [4:0] meta_q, meta_d;
   logic [4:0] sync_q, sync_d;
   logic       sclk_prev_q, sclk_prev_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] byte_q, byte_d;
   logic       dc_q, dc_d;
   logic       valid_q, valid_d;

   logic       sclk_s, sdin_s, cs_n_s, dc_s, res_n_s;
   logic       sclk_rise;
   logic       core_rst;

   assign {sclk_s, sdin_s, cs_n_s, dc_s, res_n_s} = sync_q;
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign core_rst  = ~rst | ~res_n_s;

   // Two-stage synchronizer chain and the SCLK edge register
   always_comb begin
      meta_d      = {sclk, sdin, cs_n, dc, res_n};
      sync_d      = meta_q;
      sclk_prev_d = sclk_s;
   end

   // Synchronizers only answer to rst so a panel reset can still propagate
   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q      <= SYNC_RST_VAL;
         sync_q      <= SYNC_RST_VAL;
         sclk_prev_q <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         sclk_prev_q <= sclk_prev_d;
      end
   end

   // Shift in a bit per SCLK rise; deselect throws away a partial byte
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      byte_d    = byte_q;
      dc_d      = dc_q;
      valid_d   = 1'b0;
      if (cs_n_s) begin
         bit_cnt_d = 3'd0;
      end else if (sclk_rise) begin
         shift_d   = {shift_q[6:0], sdin_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_d  = {shift_q[6:0], sdin_s};
            dc_d    = dc_s;
            valid_d = 1'b1;
         end
      end
   end

   // Receive state, cleared by either reset source
   always_ff @(posedge clk) begin
      if (core_rst) begin
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         byte_q    <= 8'h00;
         dc_q      <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         byte_q    <= byte_d;
         dc_q      <= dc_d;
         valid_q   <= valid_d;
      end
   end

   assign rx_byte    = byte_q;
   assign rx_dc      = dc_q;
   assign rx_valid   = valid_q;
   assign sync_res_n = res_n_s;

endmodule : spi_byte_rx
`default_nettype wire

// File: rtl/ssd1306_spi_sink.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ssd1306_spi_sink                                   |
// | Description : Display-side model of the 4-wire SPI link: parses  |
// |               the addressing command subset and writes data      |
// |               bytes into a page-organised 1 KiB GDDRAM that can  |
// |               be read back on rd_addr/rd_data.                   |
// |               Optional: define SSD_SINK_COUNTERS_EN to build the |
// |               saturating command/data byte counters.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module ssd1306_spi_sink #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              sdin,
   input  logic              cs_n,
   input  logic              dc,
   input  logic              res_n,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              byte_valid,
   output logic [7:0]        byte_out,
   output logic              byte_dc,
   output logic              frame_done,
   output logic              display_on,
   output logic [7:0]        contrast,
   output logic [15:0]       cmd_count,
   output logic [15:0]       data_count
);
   import ssd_sink_pkg::*;

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0]   rx_byte;
   logic         rx_dc;
   logic         rx_valid;
   logic         sync_res_n;
   logic         core_rst;

   parse_state_e state_q, state_d;
   logic [7:0]   op_q, op_d;
   logic [6:0]   arg1_q, arg1_d;
   addr_mode_e   mode_q, mode_d;
   logic [6:0]   col_q, col_d;
   logic [2:0]   page_q, page_d;
   logic [6:0]   col_start_q, col_start_d;
   logic [6:0]   col_end_q, col_end_d;
   logic [2:0]   page_start_q, page_start_d;
   logic [2:0]   page_end_q, page_end_d;
   logic         display_on_q, display_on_d;
   logic [7:0]   contrast_q, contrast_d;
   logic [7:0]   rd_data_q;

   logic         ram_we;
   logic         col_at_end;
   logic         page_at_end;

   logic [7:0]   mem [0:DEPTH-1];

   spi_byte_rx u_rx (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .sdin       (sdin),
      .cs_n       (cs_n),
      .dc         (dc),
      .res_n      (res_n),
      .rx_byte    (rx_byte),
      .rx_dc      (rx_dc),
      .rx_valid   (rx_valid),
      .sync_res_n (sync_res_n)
   );

   assign core_rst    = ~rst | ~sync_res_n;
   assign ram_we      = rx_valid & rx_dc;
   assign col_at_end  = (col_q == col_end_q);
   assign page_at_end = (page_q == page_end_q);

   // Parser next state plus pointer advance on each data write
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      arg1_d       = arg1_q;
      mode_d       = mode_q;
      col_d        = col_q;
      page_d       = page_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      page_start_d = page_start_q;
      page_end_d   = page_end_q;
      display_on_d = display_on_q;
      contrast_d   = contrast_q;

      if (rx_valid) begin
         if (rx_dc) begin
            // Data always wins: any half-received command is dropped
            state_d = IDLE;
            case (mode_q)
               HORIZ: begin
                  if (col_at_end) begin
                     col_d  = col_start_q;
                     page_d = page_at_end ? page_start_q : page_q + 3'd1;
                  end else begin
                     col_d  = col_q + 7'd1;
                  end
               end
               VERT: begin
                  if (page_at_end) begin
                     page_d = page_start_q;
                     col_d  = col_at_end ? col_start_q : col_q + 7'd1;
                  end else begin
                     page_d = page_q + 3'd1;
                  end
               end
               default: begin
                  col_d = col_at_end ? col_start_q : col_q + 7'd1;
               end
            endcase
         end else begin
            case (state_q)
               IDLE: begin
                  op_d = rx_byte;
                  if (arg_count(rx_byte) != 2'd0) begin
                     state_d = ARG1;
                  end
                  if (rx_byte[7:3] == OP_PAGE_SEL_HI) begin
                     page_d = rx_byte[2:0];
                  end
                  if (rx_byte == OP_DISP_OFF) begin
                     display_on_d = 1'b0;
                  end
                  if (rx_byte == OP_DISP_ON) begin
                     display_on_d = 1'b1;
                  end
               end
               ARG1: begin
                  arg1_d = rx_byte[6:0];
                  if (arg_count(op_q) == 2'd2) begin
                     state_d = ARG2;
                  end else begin
                     state_d = IDLE;
                     if (op_q == OP_SET_MODE && rx_byte[1:0] != 2'd3) begin
                        mode_d = addr_mode_e'(rx_byte[1:0]);
                     end
                     if (op_q == OP_CONTRAST) begin
                        contrast_d = rx_byte;
                     end
                  end
               end
               ARG2: begin
                  // Range commands commit only once both arguments arrived
                  state_d = IDLE;
                  if (op_q == OP_COL_ADDR) begin
                     col_start_d = arg1_q;
                     col_end_d   = rx_byte[6:0];
                     col_d       = arg1_q;
                  end
                  if (op_q == OP_PAGE_ADDR) begin
                     page_start_d = arg1_q[2:0];
                     page_end_d   = rx_byte[2:0];
                     page_d       = arg1_q[2:0];
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // Parser and addressing registers
   always_ff @(posedge clk) begin
      if (core_rst) begin
         state_q      <= IDLE;
         op_q         <= 8'h00;
         arg1_q       <= 7'd0;
         mode_q       <= PAGE;
         col_q        <= 7'd0;
         page_q       <= 3'd0;
         col_start_q  <= 7'd0;
         col_end_q    <= 7'd127;
         page_start_q <= 3'd0;
         page_end_q   <= 3'd7;
         display_on_q <= 1'b0;
         contrast_q   <= 8'h7F;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         arg1_q       <= arg1_d;
         mode_q       <= mode_d;
         col_q        <= col_d;
         page_q       <= page_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         page_start_q <= page_start_d;
         page_end_q   <= page_end_d;
         display_on_q <= display_on_d;
         contrast_q   <= contrast_d;
      end
   end

   // GDDRAM: never reset, read-before-write on a same-address collision
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[{page_q, col_q}] <= rx_byte;
      end
      rd_data_q <= mem[rd_addr];
   end

`ifdef SSD_SINK_COUNTERS_EN
   logic [15:0] cmd_count_q, cmd_count_d;
   logic [15:0] data_count_q, data_count_d;

   // Saturating per-kind byte counters
   always_comb begin
      cmd_count_d  = cmd_count_q;
      data_count_d = data_count_q;
      if (rx_valid) begin
         if (rx_dc) begin
            if (data_count_q != 16'hFFFF) data_count_d = data_count_q + 16'd1;
         end else begin
            if (cmd_count_q != 16'hFFFF) cmd_count_d = cmd_count_q + 16'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (core_rst) begin
         cmd_count_q  <= 16'd0;
         data_count_q <= 16'd0;
      end else begin
         cmd_count_q  <= cmd_count_d;
         data_count_q <= data_count_d;
      end
   end

   assign cmd_count  = cmd_count_q;
   assign data_count = data_count_q;
`else
   assign cmd_count  = 16'd0;
   assign data_count = 16'd0;
`endif

   assign rd_data    = rd_data_q;
   assign byte_valid = rx_valid;
   assign byte_out   = rx_byte;
   assign byte_dc    = rx_dc;
   assign frame_done = ram_we & (mode_q != PAGE) & col_at_end & page_at_end;
   assign display_on = display_on_q;
   assign contrast   = contrast_q;

endmodule : ssd1306_spi_sink
`default_nettype wire

// File: tb/tb_ssd1306_spi_sink.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_ssd1306_spi_sink                                |
// | Description : Randomized bench for ssd1306_spi_sink with a       |
// |               behavioural display model and a byte scoreboard.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ssd1306_spi_sink;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sclk = 1'b0;
   logic        sdin = 1'b0;
   logic        cs_n = 1'b1;
   logic        dc = 1'b0;
   logic        res_n = 1'b1;
   logic [9:0]  rd_addr = 10'd0;
   logic [7:0]  rd_data;
   logic        byte_valid;
   logic [7:0]  byte_out;
   logic        byte_dc;
   logic        frame_done;
   logic        display_on;
   logic [7:0]  contrast;
   logic [15:0] cmd_count;
   logic [15:0] data_count;

   ssd1306_spi_sink #(.ADDR_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .sdin       (sdin),
      .cs_n       (cs_n),
      .dc         (dc),
      .res_n      (res_n),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .byte_valid (byte_valid),
      .byte_out   (byte_out),
      .byte_dc    (byte_dc),
      .frame_done (frame_done),
      .display_on (display_on),
      .contrast   (contrast),
      .cmd_count  (cmd_count),
      .data_count (data_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_fd = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural display model ----------------
   typedef struct packed {
      logic       d;
      logic [7:0] b;
      logic       fd;
   } exp_t;
   exp_t sb[$];

   int         m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
   int         m_need, m_cmd_cnt, m_dat_cnt;
   int         m_disp, m_contrast;
   int         m_args[$];
   logic [7:0] m_ram [1024];

   function automatic void model_reset();
      m_mode = 2; m_col = 0; m_page = 0;
      m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
      m_need = 0; m_args.delete();
      m_disp = 0; m_contrast = 8'h7F;
      m_cmd_cnt = 0; m_dat_cnt = 0;
   endfunction

   function automatic int nargs(input int op);
      case (op)
         'h20, 'h81, 'hA8, 'hD3, 'h8D, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
         'h21, 'h22: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic void model_exec();
      int op = m_args[0];
      if (op == 'h20 && (m_args[1] % 4) != 3) m_mode = m_args[1] % 4;
      if (op == 'h81) m_contrast = m_args[1];
      if (op == 'h21) begin m_cs = m_args[1] % 128; m_ce = m_args[2] % 128; m_col = m_cs; end
      if (op == 'h22) begin m_ps = m_args[1] % 8; m_pe = m_args[2] % 8; m_page = m_ps; end
      m_args.delete();
   endfunction

   // Applies one complete byte; returns whether it ends a frame
   function automatic bit model_byte(input bit d, input int b);
      bit fd = 1'b0;
      if (d) begin
         if (m_dat_cnt < 65535) m_dat_cnt++;
         m_need = 0; m_args.delete();
         fd = (m_mode != 2) && (m_col == m_ce) && (m_page == m_pe);
         m_ram[m_page * 128 + m_col] = b[7:0];
         if (m_mode == 0) begin
            if (m_col == m_ce) begin
               m_col = m_cs;
               m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
            end else m_col = (m_col + 1) % 128;
         end else if (m_mode == 1) begin
            if (m_page == m_pe) begin
               m_page = m_ps;
               m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
            end else m_page = (m_page + 1) % 8;
         end else begin
            m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
         end
      end else begin
         if (m_cmd_cnt < 65535) m_cmd_cnt++;
         if (m_need > 0) begin
            m_args.push_back(b);
            m_need--;
            if (m_need == 0) model_exec();
         end else begin
            m_args.delete();
            m_args.push_back(b);
            m_need = nargs(b);
            if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
            if (b == 'hAE) m_disp = 0;
            if (b == 'hAF) m_disp = 1;
            if (m_need == 0) m_args.delete();
         end
      end
      return fd;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send_bits(input bit dv, input logic [7:0] b, input int nbits);
      cs_n = 1'b0;
      dc   = dv;
      for (int i = 0; i < nbits; i++) begin
         sdin = b[7 - i];
         repeat ($urandom_range(2, 3)) @(negedge clk);
         sclk = 1'b1;
         repeat ($urandom_range(2, 3)) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic send(input bit dv, input int b);
      exp_t e;
      e.d  = dv;
      e.b  = b[7:0];
      e.fd = model_byte(dv, b);
      sb.push_back(e);
      send_bits(dv, b[7:0], 8);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb.size(), 0);
      sb.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic ram_check(input int a);
      rd_addr = a[9:0];
      @(negedge clk);
      chk($sformatf("ram[%0d]", a), rd_data, m_ram[a]);
   endtask

   task automatic status_check();
      chk("display_on", display_on, m_disp);
      chk("contrast", contrast, m_contrast);
`ifdef SSD_SINK_COUNTERS_EN
      chk("cmd_count", cmd_count, m_cmd_cnt);
      chk("data_count", data_count, m_dat_cnt);
`else
      chk("cmd_count", cmd_count, 0);
      chk("data_count", data_count, 0);
`endif
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (byte_valid) begin
         n_valid++;
         if (frame_done) n_fd++;
         if (sb.size() == 0) begin
            chk("unexpected_byte_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("byte_out", byte_out, e.b);
            chk("byte_dc", byte_dc, e.d);
            chk("frame_done", frame_done, e.fd);
         end
      end else if (frame_done) begin
         chk("frame_done_without_valid", 1, 0);
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int base;
      int op;
      model_reset();
      for (int a = 0; a < 1024; a++) m_ram[a] = 8'h00;

      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_byte_out", byte_out, 0);
      chk("rst_byte_dc", byte_dc, 0);
      chk("rst_frame_done", frame_done, 0);
      status_check();
      chk("rst_contrast_const", contrast, 'h7F);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Display on, then one data byte at the origin
      base = n_valid;
      send(0, 'hAF);
      send(1, 'h55);
      drain();
      chk("two_pulses", n_valid - base, 2);
      chk("display_on_const", display_on, 1);
      rd_addr = 10'd0;
      @(negedge clk);
      chk("ram0_const", rd_data, 'h55);
      status_check();

      // Full-screen horizontal fill
      send(0, 'h20); send(0, 'h00);
      send(0, 'h21); send(0, 'h00); send(0, 'h7F);
      send(0, 'h22); send(0, 'h00); send(0, 'h07);
      base = n_fd;
      for (int i = 0; i < 1024; i++) send(1, i % 256);
      drain();
      chk("fill_frame_done_count", n_fd - base, 1);
      for (int a = 0; a < 1024; a++) ram_check(a);

      // Vertical window 2..3 x 6..7
      send(0, 'h20); send(0, 'h01);
      send(0, 'h21); send(0, 'h02); send(0, 'h03);
      send(0, 'h22); send(0, 'h06); send(0, 'h07);
      for (int i = 1; i <= 4; i++) send(1, 'hA0 + i);
      drain();
      rd_addr = 10'd770; @(negedge clk); chk("vert_6_2", rd_data, 'hA1);
      rd_addr = 10'd898; @(negedge clk); chk("vert_7_2", rd_data, 'hA2);
      rd_addr = 10'd771; @(negedge clk); chk("vert_6_3", rd_data, 'hA3);
      rd_addr = 10'd899; @(negedge clk); chk("vert_7_3", rd_data, 'hA4);

      // Partial byte discarded on deselect
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      send_bits(1, 8'hE7, 5);
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
      base = n_valid;
      send(1, 'h3C);
      drain();
      chk("partial_one_pulse", n_valid - base, 1);
      chk("partial_byte_out", byte_out, 'h3C);

      // Data aborts a pending contrast command
      send(0, 'h81);
      send(1, 'h99);
      drain();
      chk("abort_contrast", contrast, 'h7F);
      status_check();

      // Panel reset in the middle of a byte
      send_bits(1, 8'hF0, 3);
      res_n = 1'b0;
      repeat (4) @(negedge clk);
      res_n = 1'b1;
      cs_n  = 1'b1;
      model_reset();
      repeat (6) @(negedge clk);
      chk("resn_byte_out", byte_out, 0);
      status_check();
      send(1, 'h11);
      drain();
      rd_addr = 10'd0; @(negedge clk); chk("resn_ram0", rd_data, 'h11);
      rd_addr = 10'd1; @(negedge clk); chk("resn_ram1_kept", rd_data, 'h01);

      // Randomized command/data mix
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) < 5) begin
            send(1, $urandom_range(0, 255));
         end else begin
            case ($urandom_range(0, 7))
               0: op = 'h20;
               1: op = 'h21;
               2: op = 'h22;
               3: op = 'h81;
               4: op = 'hAE + $urandom_range(0, 1);
               5: op = 'hB0 + $urandom_range(0, 7);
               6: op = 'hA8;
               default: op = $urandom_range(0, 255);
            endcase
            send(0, op);
            for (int k = 0; k < nargs(op); k++) begin
               if ($urandom_range(0, 9) == 0) send(1, $urandom_range(0, 255));
               else send(0, $urandom_range(0, 255));
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            cs_n = 1'b1;
            repeat (3) @(negedge clk);
         end
      end
      drain();
      status_check();
      for (int a = 0; a < 1024; a++) ram_check(a);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ssd1306_spi_sink
`default_nettype wire

// File: doc/ssd1306_spi_sink.md
# ssd1306_spi_sink

Behavioural-synthesizable model of the SSD1306 display side of our 4-wire SPI display link. It deserializes SCLK/SDIN under CS/DC, executes the addressing subset of the controller's command set, and writes data bytes into a 1024-byte page-organised GDDRAM. The GDDRAM can be read back by a bench or an on-chip checker, so the screen driver and text renderer can be verified end-to-end without a physical panel.

## Interface
Parameters:
- ADDR_W, 10, GDDRAM address width (8 pages x 128 columns).

Ports:
- clk  in  1  system clock; the same clock that generates SCLK in the driver.
- rst  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from the driver; idle level is don't-care.
- sdin  in  1  SPI data, MSB first.
- cs_n  in  1  chip select, active-low.
- dc  in  1  0 = command byte, 1 = data byte.
- res_n  in  1  panel reset, active-low.
- rd_addr  in  10  GDDRAM read address, {page[2:0], col[6:0]}.
- rd_data  out  8  GDDRAM read data.
- byte_valid  out  1  one-clk pulse per completed byte.
- byte_out  out  8  last completed byte.
- byte_dc  out  1  DC latched with the last byte.
- frame_done  out  1  one-clk pulse on the write to (col_end, page_end).
- display_on  out  1  set by 0xAF, cleared by 0xAE.
- contrast  out  8  argument of 0x81.
- cmd_count, data_count  out  16 each  byte counters (see Configuration).

## Operation
- sclk, sdin, cs_n, dc, res_n pass through 2-FF synchronizers; an SCLK rising edge is detected on the synchronized signal.
- On each rising edge with cs_n low: shift sdin into the shift register and increment the bit counter. On the 8th bit, latch the byte and DC, then pulse byte_valid.
- cs_n high clears the bit counter. A partial byte is discarded and produces no pulse. The command-parser state is retained across CS toggles.
- Parser states: IDLE, ARG1, ARG2.
  - In IDLE, a command byte is decoded:
    - 0x20: 1 argument; mode[1:0]: 0 = horizontal, 1 = vertical, 2 = page, 3 = ignored.
    - 0x21: 2 arguments; col_start, col_end (7 bits each). Sets col = col_start.
    - 0x22: 2 arguments; page_start, page_end (3 bits each). Sets page = page_start.
    - 0x81: 1 argument; contrast.
    - 0xA8, 0xD3, 0x8D, 0xD5, 0xD9, 0xDA, 0xDB: 1 argument, discarded.
    - 0xB0–0xB7: sets page = byte[2:0].
    - 0xAE / 0xAF: display_on.
    - Any other opcode: ignored, no arguments.
  - A data byte (dc = 1) in ARG1/ARG2 aborts the pending command: the parser returns to IDLE and the byte is written as data.
- Data write: ram[{page, col}] <= byte. The pointer then advances:
  - Horizontal: col++. When col == col_end: col = col_start and page++; when page == page_end, page = page_start.
  - Vertical: page++. When page == page_end: page = page_start and col++; when col == col_end, col = col_start.
  - Page: col++. When col == col_end, col = col_start; page unchanged.
- frame_done pulses with the write at (col_end, page_end) in horizontal and vertical modes only.
- res_n low, or rst low, sets:
  - parser = IDLE, bit counter = 0
  - mode = 2 (page), col = 0, page = 0
  - col_start = 0, col_end = 127, page_start = 0, page_end = 7
  - display_on = 0, contrast = 0x7F
  - all pulse outputs = 0, byte_out = 0, byte_dc = 0, counters = 0
- GDDRAM is not cleared by any reset; it initializes to 0x00 at configuration.

## Timing
- SCLK high and low phases must each be at least 2 clk. Shorter phases are unsupported and may drop bits.
- byte_valid is asserted 3 clk after the 8th SCLK rising edge at the pin (2 synchronizer stages plus the edge register). The GDDRAM write and the pointer update occur in that same cycle. frame_done is coincident with byte_valid.
- rd_data is registered: data for rd_addr presented in cycle N appears in cycle N+1. A read of the address being written in the same cycle returns the old data.
- rst has priority over res_n. Both are sampled synchronously; res_n is sampled after its synchronizer.

## Configuration
- SSD_SINK_COUNTERS_EN defined: cmd_count and data_count count bytes with byte_dc = 0 and byte_dc = 1 respectively. They saturate at 0xFFFF and are cleared by rst and by res_n.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Structure
- Package ssd_sink_pkg holds:
  - opcode constants
  - addressing-mode enum (HORIZ, VERT, PAGE)
  - parser state enum
  - a function mapping an opcode to its argument count (0–2)
- Sub-module spi_byte_rx holds the synchronizers, edge detect, shift register and bit counter. Its outputs are byte, dc, valid and sync_res_n.

## Test plan
- After reset, send command 0xAF, then data 0x55 -> display_on = 1; ram[0x000] = 0x55; byte_valid pulses twice; data_count = 1.
- Send 0x20 0x00, 0x21 0x00 0x7F, 0x22 0x00 0x07, then 1024 data bytes of value i[7:0] -> ram[a] = a[7:0] for all a; frame_done pulses once, on byte 1023.
- Vertical mode with 0x21 0x02 0x03 and 0x22 0x06 0x07, then 4 data bytes A1..A4 -> written to {6,2}, {7,2}, {6,3}, {7,3} in that order.
- Raise cs_n after 5 bits, then send a full data byte 0x3C -> exactly one byte_valid, with byte_out = 0x3C.
- Send 0x81, then data 0x99 -> contrast unchanged at 0x7F; 0x99 is written at the current pointer.
- Pulse res_n low mid-byte, then send data 0x11 -> mode = page and col = 0; 0x11 lands at {0,0} and earlier RAM contents are preserved.
